// File: rtl/i_o_uart_pkg.sv
// Shared UART definitions for the I/O subsystem: receiver FSM states, frame
// width and the bit-period counter sizing helper.
package i_o_uart_pkg;

   localparam int UART_DATA_BITS = 8;

   typedef enum logic [2:0] {
      IDLE,
      START,
      DATA,
      STOP,
      BREAK
   } uart_rx_state_t;

   // Width of a counter that must reach period-1; never narrower than one bit.
   function automatic int uart_cnt_width(input int period);
      return (period > 2) ? $clog2(period) : 1;
   endfunction

endpackage

// File: rtl/i_o_sync2.sv
// Two-flop synchroniser for a single asynchronous input; RESET_VAL selects
// the value both flops take while rst_n is low.
module i_o_sync2 #(
   parameter logic RESET_VAL = 1'b1
) (
   input  logic clk,
   input  logic rst_n,
   input  logic d_i,
   output logic q_o
);

   logic meta_q;
   logic sync_q;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q <= RESET_VAL;
         sync_q <= RESET_VAL;
      end else begin
         meta_q <= d_i;
         sync_q <= meta_q;
      end
   end

   assign q_o = sync_q;

endmodule

// File: rtl/i_o_uart_receiver.sv
// 8N1 UART receiver: mid-bit sampling with a counter re-aligned on each start
// bit, one-entry holding register with valid/ready, frame error and overrun.
module i_o_uart_receiver
   import i_o_uart_pkg::*;
#(
   parameter int CLOCK_FREQ  = 100000000,
   parameter int BAUD_RATE   = 115200,
   parameter int BIT_PERIOD  = CLOCK_FREQ / BAUD_RATE,
   parameter int HALF_PERIOD = BIT_PERIOD / 2
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       rx,
   output logic [7:0] data,
   output logic       valid,
   input  logic       ready,
   output logic       frame_error,
   output logic       overrun,
   output logic       busy
);

   localparam int CW = uart_cnt_width(BIT_PERIOD);
   localparam logic [CW-1:0] CNT_FULL = CW'(BIT_PERIOD - 1);
   localparam logic [CW-1:0] CNT_HALF = CW'(HALF_PERIOD - 1);
   localparam logic [2:0]    LAST_BIT = 3'(UART_DATA_BITS - 1);

   logic                      rx_s;
   uart_rx_state_t            state_q;
   logic [CW-1:0]             cnt_q;
   logic [2:0]                bit_idx_q;
   logic [UART_DATA_BITS-1:0] shift_q;
   logic [UART_DATA_BITS-1:0] shift_d;
   logic [UART_DATA_BITS-1:0] data_q;
   logic                      valid_q;
   logic                      deliver_q;
   logic                      frame_err_q;
   logic                      overrun_q;

   i_o_sync2 #(.RESET_VAL(1'b1)) u_rx_sync (
      .clk   (clk),
      .rst_n (rst_n),
      .d_i   (rx),
      .q_o   (rx_s)
   );

   // LSB arrives first, so each new sample enters at the top and shifts down.
   assign shift_d = {rx_s, shift_q[UART_DATA_BITS-1:1]};

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= IDLE;
         cnt_q       <= '0;
         bit_idx_q   <= '0;
         shift_q     <= '0;
         data_q      <= '0;
         valid_q     <= 1'b0;
         deliver_q   <= 1'b0;
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
      end else begin
         frame_err_q <= 1'b0;
         overrun_q   <= 1'b0;
         deliver_q   <= 1'b0;

         // Holding register: a byte lands one cycle after its good stop sample.
         if (deliver_q) begin
            if (!valid_q || ready) begin
               data_q  <= shift_q;
               valid_q <= 1'b1;
            end else begin
               overrun_q <= 1'b1;
            end
         end else if (valid_q && ready) begin
            valid_q <= 1'b0;
         end

         case (state_q)
            IDLE: begin
               if (!rx_s) begin
                  cnt_q   <= '0;
                  state_q <= START;
               end
            end
            START: begin
               if (cnt_q == CNT_HALF) begin
                  if (!rx_s) begin
                     cnt_q     <= '0;
                     bit_idx_q <= '0;
                     state_q   <= DATA;
                  end else begin
                     state_q <= IDLE;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            DATA: begin
               if (cnt_q == CNT_FULL) begin
                  shift_q   <= shift_d;
                  cnt_q     <= '0;
                  bit_idx_q <= bit_idx_q + 3'd1;
                  if (bit_idx_q == LAST_BIT) begin
                     state_q <= STOP;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            STOP: begin
               if (cnt_q == CNT_FULL) begin
                  cnt_q <= '0;
                  if (rx_s) begin
                     deliver_q <= 1'b1;
                     state_q   <= IDLE;
                  end else begin
                     frame_err_q <= 1'b1;
                     state_q     <= BREAK;
                  end
               end else begin
                  cnt_q <= cnt_q + 1'b1;
               end
            end
            BREAK: begin
               // A held-low line must return high before a new start is armed.
               if (rx_s) begin
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign data        = data_q;
   assign valid       = valid_q;
   assign frame_error = frame_err_q;
   assign overrun     = overrun_q;
   assign busy        = (state_q != IDLE);

endmodule

// File: tb/tb_i_o_uart_receiver.sv
// Directed bench for i_o_uart_receiver at 16 clocks per bit: normal frames,
// overrun, framing error with break, start glitch, mid-frame reset, back-to-back.
module tb_i_o_uart_receiver;

   localparam int BP = 16;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       rx = 1'b1;
   logic       ready = 1'b0;
   logic [7:0] data;
   logic       valid;
   logic       frame_error;
   logic       overrun;
   logic       busy;

   int tests_run = 0;
   int tests_failed = 0;

   int cycle = 0;
   int start_cycle = 0;
   int last_rise_cycle = 0;
   int valid_rise_cnt = 0;
   int valid_hi_cnt = 0;
   int fe_cnt = 0;
   int ov_cnt = 0;
   int both_cnt = 0;
   logic valid_prev = 1'b0;
   logic [7:0] rx_q[$];

   always #5 clk = ~clk;

   i_o_uart_receiver #(
      .CLOCK_FREQ (1600),
      .BAUD_RATE  (100)
   ) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .rx          (rx),
      .data        (data),
      .valid       (valid),
      .ready       (ready),
      .frame_error (frame_error),
      .overrun     (overrun),
      .busy        (busy)
   );

   always @(posedge clk) cycle++;

   // Passive monitor, sampled on the falling edge.
   always @(negedge clk) begin
      if (rst_n) begin
         if (valid && ready) rx_q.push_back(data);
         if (valid && !valid_prev) begin
            valid_rise_cnt++;
            last_rise_cycle = cycle;
         end
         if (valid) valid_hi_cnt++;
         if (frame_error) fe_cnt++;
         if (overrun) ov_cnt++;
         if (frame_error && overrun) both_cnt++;
      end
      valid_prev = valid;
   end

   task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests_run++;
      if (obs !== exp) begin
         tests_failed++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
      end else begin
         $display("ok   %s: 0x%0h", tag, obs);
      end
   endtask

   task automatic drive_bits(input logic v, input int n);
      rx = v;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] b);
      start_cycle = cycle;
      drive_bits(1'b0, BP);
      for (int i = 0; i < 8; i++) drive_bits(b[i], BP);
      drive_bits(1'b1, BP);
   endtask

   task automatic check_next_byte(input string tag, input logic [7:0] exp);
      logic [7:0] got;
      got = 8'hxx;
      if (rx_q.size() > 0) got = rx_q.pop_front();
      check_eq(tag, {24'd0, got}, {24'd0, exp});
   endtask

   initial begin
      int fe0, ov0, vh0, lat;
      logic [7:0] b55;

      repeat (3) @(negedge clk);
      check_eq("reset_data", {24'd0, data}, 32'h0);
      check_eq("reset_valid", valid, 0);
      check_eq("reset_frame_error", frame_error, 0);
      check_eq("reset_overrun", overrun, 0);
      check_eq("reset_busy", busy, 0);
      rst_n = 1'b1;
      repeat (4) @(negedge clk);

      // Single frame, consumer always ready.
      ready = 1'b1;
      fe0 = fe_cnt; ov0 = ov_cnt; vh0 = valid_hi_cnt;
      send_frame(8'hA5);
      repeat (4) @(negedge clk);
      check_eq("a5_count", rx_q.size(), 1);
      check_next_byte("a5_data", 8'hA5);
      lat = last_rise_cycle - start_cycle;
      check_eq($sformatf("a5_latency_in_window(lat=%0d)", lat), (lat >= 153 && lat <= 159), 1);
      check_eq("a5_valid_cycles", valid_hi_cnt - vh0, 1);
      check_eq("a5_no_frame_error", fe_cnt - fe0, 0);
      check_eq("a5_no_overrun", ov_cnt - ov0, 0);

      // Two frames with the consumer stalled: second one overruns.
      ready = 1'b0;
      fe0 = fe_cnt; ov0 = ov_cnt;
      send_frame(8'h3C);
      send_frame(8'hC3);
      repeat (4) @(negedge clk);
      check_eq("ovr_valid_held", valid, 1);
      check_eq("ovr_data_held", {24'd0, data}, 32'h3C);
      check_eq("ovr_pulse_count", ov_cnt - ov0, 1);
      check_eq("ovr_no_frame_error", fe_cnt - fe0, 0);
      ready = 1'b1;
      @(negedge clk);
      @(negedge clk);
      check_eq("ovr_valid_cleared", valid, 0);
      check_eq("ovr_data_kept", {24'd0, data}, 32'h3C);
      rx_q.delete();

      // Stop bit held low for three bit times.
      fe0 = fe_cnt; ov0 = ov_cnt;
      b55 = 8'h55;
      drive_bits(1'b0, BP);
      for (int i = 0; i < 8; i++) drive_bits(b55[i], BP);
      drive_bits(1'b0, 3 * BP);
      check_eq("ferr_busy_in_break", busy, 1);
      check_eq("ferr_pulse_count", fe_cnt - fe0, 1);
      check_eq("ferr_valid_low", valid, 0);
      drive_bits(1'b1, BP);
      check_eq("ferr_busy_released", busy, 0);
      check_eq("ferr_nothing_delivered", rx_q.size(), 0);
      check_eq("ferr_no_overrun", ov_cnt - ov0, 0);
      send_frame(8'h81);
      repeat (4) @(negedge clk);
      check_next_byte("after_ferr_data", 8'h81);

      // Four-clock low glitch from idle.
      fe0 = fe_cnt; ov0 = ov_cnt;
      drive_bits(1'b0, 4);
      drive_bits(1'b1, 30);
      check_eq("glitch_busy", busy, 0);
      check_eq("glitch_valid", valid, 0);
      check_eq("glitch_nothing_delivered", rx_q.size(), 0);
      check_eq("glitch_no_pulses", (fe_cnt - fe0) + (ov_cnt - ov0), 0);

      // Reset in the middle of a 0xFF frame.
      drive_bits(1'b0, BP);
      drive_bits(1'b1, 3 * BP);
      rst_n = 1'b0;
      #1;
      check_eq("midrst_data", {24'd0, data}, 32'h0);
      check_eq("midrst_valid", valid, 0);
      check_eq("midrst_busy", busy, 0);
      check_eq("midrst_pulses", {30'd0, frame_error, overrun}, 32'h0);
      drive_bits(1'b1, 5);
      rst_n = 1'b1;
      drive_bits(1'b1, 6 * BP);
      send_frame(8'h12);
      repeat (4) @(negedge clk);
      check_eq("midrst_count", rx_q.size(), 1);
      check_next_byte("midrst_data_12", 8'h12);

      // Back-to-back frames, no idle gap.
      send_frame(8'h00);
      send_frame(8'hFF);
      send_frame(8'h7E);
      repeat (4) @(negedge clk);
      check_eq("b2b_count", rx_q.size(), 3);
      check_next_byte("b2b_first", 8'h00);
      check_next_byte("b2b_second", 8'hFF);
      check_next_byte("b2b_third", 8'h7E);

      check_eq("never_ferr_and_ovr_together", both_cnt, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
